vmicro16_apb_rr_arbiter: RTL and testbench
==========================================

# vmicro16_apb_rr_arbiter

Round-robin APB arbiter that shares one APB master port among the `MASTER_PORTS` core-side APB masters of a vmicro16 cluster. It sits between the cores' data-bus APB ports and the cluster's single outbound port toward the SoC data interconnect. It serialises transfers, latches the winning request, and routes the completion (`PRDATA`/`PREADY`) back to the winning core only. A watchdog aborts transfers the slave never completes.

## Interface
- `BUS_WIDTH`, 16: APB address width.
- `DATA_WIDTH`, 16: APB data width.
- `MASTER_PORTS`, 4: number of requesting cores; must be 1..16.
- `TIMEOUT`, 255: maximum ACCESS cycles before abort; 0 disables the watchdog; must be at most 255.

- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  reset, synchronous, active-low (0 = reset).
- `S_PADDR`  in  MASTER_PORTS*BUS_WIDTH  per-core address, core c at `[c*BUS_WIDTH +: BUS_WIDTH]`.
- `S_PWRITE`  in  MASTER_PORTS  per-core write strobe.
- `S_PSELx`  in  MASTER_PORTS  per-core request.
- `S_PENABLE`  in  MASTER_PORTS  per-core enable; ignored for arbitration.
- `S_PWDATA`  in  MASTER_PORTS*DATA_WIDTH  per-core write data.
- `S_PRDATA`  out  MASTER_PORTS*DATA_WIDTH  per-core read data.
- `S_PREADY`  out  MASTER_PORTS  per-core completion.
- `M_PADDR`  out  BUS_WIDTH; `M_PWRITE`  out  1; `M_PSELx`  out  1; `M_PENABLE`  out  1; `M_PWDATA`  out  DATA_WIDTH: shared outbound APB master.
- `M_PRDATA`  in  DATA_WIDTH; `M_PREADY`  in  1: outbound completion.
- `grant`  out  MASTER_PORTS  one-hot index of the current owner; 0 when IDLE.
- `timeout_err`  out  1  one-cycle pulse on a watchdog abort.

## Operation
- FSM states: IDLE, SETUP, ACCESS.
- IDLE: if any `S_PSELx` bit is set, select the first set bit at or after `rr_ptr`, searching upward modulo MASTER_PORTS.
  - Latch the winner's index, `S_PADDR`, `S_PWRITE` and `S_PWDATA`.
  - Set `grant`.
  - Move to SETUP.
  - With no request, stay in IDLE.
- SETUP: `M_PSELx`=1, `M_PENABLE`=0, `M_*` driven from the latched values. Always moves to ACCESS.
- ACCESS: `M_PSELx`=1, `M_PENABLE`=1.
  - Wait counter increments every ACCESS cycle.
  - On `M_PREADY`=1: completion. Then `rr_ptr` ← (winner+1) mod MASTER_PORTS, and the FSM goes to IDLE.
  - Else if TIMEOUT≠0 and the counter = TIMEOUT−1: abort. `S_PREADY[winner]`=1, `S_PRDATA[winner]`=0, `timeout_err`=1 for that cycle. Then the same pointer update and return to IDLE as a completion.
- Completion routing (combinational, ACCESS only):
  - `S_PREADY[winner]` = `M_PREADY`; `S_PRDATA[winner]` = `M_PRDATA`.
  - All other `S_PREADY` = 0 and all other `S_PRDATA` = 0.
  - Outside ACCESS, every `S_PREADY` = 0 and every `S_PRDATA` = 0.
- Cores hold `PSELx` until they see their `PREADY`; losers therefore simply wait.
- A core that re-requests immediately after completion is re-arbitrated. `rr_ptr` has already advanced past it, so any other pending core wins first.
- `S_*` changes after latching do not affect the in-flight transfer.
- MASTER_PORTS=1: the pointer stays 0; behaviour is otherwise identical.

## Timing
- Reset (`reset`=0 at an edge):
  - FSM → IDLE; `rr_ptr`, latches and the wait counter → 0.
  - All `M_*` outputs = 0; `grant` = 0; `timeout_err` = 0; all `S_PREADY` and `S_PRDATA` = 0.
- Reset asserted mid-transfer abandons the transfer: no `S_PREADY` is issued, and `M_PSELx` falls after the reset edge.
- Request first visible in IDLE at cycle n:
  - SETUP in n+1.
  - ACCESS in n+2.
  - With a zero-wait slave, `S_PREADY` is high in n+2.
  - IDLE in n+3.
- Minimum transfer occupancy: 3 cycles, including the IDLE arbitration cycle. Each slave wait state adds 1 cycle.
- Timeout abort occurs in the TIMEOUT-th ACCESS cycle.
- `M_PREADY` and the timeout in the same cycle: treated as a normal completion (real `M_PRDATA`, no `timeout_err`).
- `M_PREADY` is ignored outside ACCESS.

## Test plan
- Single read, one core: core 1 reads 0x0040 and the slave returns 0x1234 with no wait states → `M_PSELx` rises 1 cycle after the request; `S_PREADY[1]`=1 with `S_PRDATA[1]`=0x1234 two cycles after the request; `grant`=4'b0010; other `S_PREADY` stay 0.
- Simultaneous requests: all 4 cores write (core c writes data 0x00c0+c) from reset → `M_PWDATA` sequence is 0x00C0, 0x00C1, 0x00C2, 0x00C3, one transfer every 3 cycles.
- Fairness: core 2 is served; then cores 0 and 2 request again together → core 0 wins (`rr_ptr`=3 wraps to 0), then core 2.
- Wait states: slave holds `M_PREADY`=0 for 5 ACCESS cycles → `M_PADDR`/`M_PWDATA` stay stable; `S_PREADY` is asserted only on the 6th ACCESS cycle.
- Timeout: TIMEOUT=8 and the slave never readies → on the 8th ACCESS cycle, `S_PREADY[winner]`=1, `S_PRDATA`=0, `timeout_err`=1 for 1 cycle; FSM returns to IDLE.
- Reset mid-transfer: drive `reset`=0 in ACCESS → next cycle all outputs are 0 and `grant`=0; no `S_PREADY` pulse; after release, cores 0 and 3 requesting together are served core 0 first.

Source files
------------

// File: rtl/vmicro16_apb_rr_arbiter.sv
// Round-robin arbiter sharing one outbound APB master among MASTER_PORTS core-side APB masters,
// with completion routed back to the winning core and a watchdog that aborts stuck transfers.
module vmicro16_apb_rr_arbiter #(
    parameter int BUS_WIDTH    = 16,
    parameter int DATA_WIDTH   = 16,
    parameter int MASTER_PORTS = 4,
    parameter int TIMEOUT      = 255
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [MASTER_PORTS*BUS_WIDTH-1:0]  S_PADDR,
    input  logic [MASTER_PORTS-1:0]            S_PWRITE,
    input  logic [MASTER_PORTS-1:0]            S_PSELx,
    input  logic [MASTER_PORTS-1:0]            S_PENABLE,
    input  logic [MASTER_PORTS*DATA_WIDTH-1:0] S_PWDATA,
    output logic [MASTER_PORTS*DATA_WIDTH-1:0] S_PRDATA,
    output logic [MASTER_PORTS-1:0]            S_PREADY,
    output logic [BUS_WIDTH-1:0]               M_PADDR,
    output logic                               M_PWRITE,
    output logic                               M_PSELx,
    output logic                               M_PENABLE,
    output logic [DATA_WIDTH-1:0]              M_PWDATA,
    input  logic [DATA_WIDTH-1:0]              M_PRDATA,
    input  logic                               M_PREADY,
    output logic [MASTER_PORTS-1:0]            grant,
    output logic                               timeout_err,
    output logic [1:0]                         fsm_state
);
    // Handshake: a core holds PSELx (with its address/data stable) until it sees its own PREADY;
    // the outbound side follows APB SETUP then ACCESS, and completes on the first ACCESS cycle with M_PREADY=1.

    localparam int IW = (MASTER_PORTS > 1) ? $clog2(MASTER_PORTS) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    state_t                  state;
    logic [IW-1:0]           rr_ptr;
    logic [IW-1:0]           winner;
    logic [IW-1:0]           win_idx;
    logic [IW-1:0]           ptr_next;
    logic                    win_found;
    logic [BUS_WIDTH-1:0]    addr_q;
    logic                    write_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [7:0]              wait_cnt;
    logic                    psel_q;
    logic                    penable_q;
    logic [MASTER_PORTS-1:0] grant_next;
    logic [BUS_WIDTH-1:0]    sel_addr;
    logic                    sel_write;
    logic [DATA_WIDTH-1:0]   sel_wdata;
    logic                    abort;
    logic                    done;

    // Core-side PENABLE carries no information the arbiter needs.
    logic unused_penable;
    assign unused_penable = ^S_PENABLE;

    // First pass searches upward from the pointer, second pass wraps to the lowest requester.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int i = 0; i < MASTER_PORTS; i++) begin
            if (!win_found && (i >= int'(rr_ptr)) && S_PSELx[i]) begin
                win_found = 1'b1;
                win_idx   = IW'(i);
            end
        end
        for (int i = 0; i < MASTER_PORTS; i++) begin
            if (!win_found && S_PSELx[i]) begin
                win_found = 1'b1;
                win_idx   = IW'(i);
            end
        end
    end

    always_comb begin
        sel_addr   = '0;
        sel_write  = 1'b0;
        sel_wdata  = '0;
        grant_next = '0;
        for (int i = 0; i < MASTER_PORTS; i++) begin
            if (win_found && (win_idx == IW'(i))) begin
                sel_addr      = S_PADDR[i*BUS_WIDTH +: BUS_WIDTH];
                sel_write     = S_PWRITE[i];
                sel_wdata     = S_PWDATA[i*DATA_WIDTH +: DATA_WIDTH];
                grant_next[i] = 1'b1;
            end
        end
    end

    // A real completion in the deadline cycle takes precedence over the abort.
    assign abort    = (TIMEOUT != 0) && (state == ACCESS) && !M_PREADY &&
                      (wait_cnt == 8'(TIMEOUT - 1));
    assign done     = (state == ACCESS) && (M_PREADY || abort);
    assign ptr_next = (winner == IW'(MASTER_PORTS - 1)) ? '0 : winner + IW'(1);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            winner    <= '0;
            addr_q    <= '0;
            write_q   <= 1'b0;
            wdata_q   <= '0;
            wait_cnt  <= '0;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            grant     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (win_found) begin
                        winner  <= win_idx;
                        addr_q  <= sel_addr;
                        write_q <= sel_write;
                        wdata_q <= sel_wdata;
                        grant   <= grant_next;
                        psel_q  <= 1'b1;
                        state   <= SETUP;
                    end
                end
                SETUP: begin
                    penable_q <= 1'b1;
                    wait_cnt  <= '0;
                    state     <= ACCESS;
                end
                ACCESS: begin
                    wait_cnt <= wait_cnt + 8'd1;
                    if (done) begin
                        rr_ptr    <= ptr_next;
                        grant     <= '0;
                        psel_q    <= 1'b0;
                        penable_q <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Address/data are shown only while a transfer owns the bus.
    assign M_PSELx   = psel_q;
    assign M_PENABLE = penable_q;
    assign M_PADDR   = psel_q ? addr_q  : '0;
    assign M_PWRITE  = psel_q & write_q;
    assign M_PWDATA  = psel_q ? wdata_q : '0;

    // Completion is suppressed while reset is held so an abandoned transfer never reports done.
    always_comb begin
        S_PREADY = '0;
        S_PRDATA = '0;
        for (int i = 0; i < MASTER_PORTS; i++) begin
            if ((state == ACCESS) && reset && (winner == IW'(i))) begin
                S_PREADY[i]                        = M_PREADY | abort;
                S_PRDATA[i*DATA_WIDTH +: DATA_WIDTH] = M_PREADY ? M_PRDATA : '0;
            end
        end
    end

    assign timeout_err = abort && reset;
    assign fsm_state   = state;

endmodule

// File: tb/tb_vmicro16_apb_rr_arbiter.sv
// Directed bench for vmicro16_apb_rr_arbiter: vector table of single transfers plus
// hand-written sequences for simultaneous requests, fairness, timeout and mid-transfer reset.
module tb_vmicro16_apb_rr_arbiter;
    localparam int BW = 16;
    localparam int DW = 16;
    localparam int NP = 4;
    localparam int TO = 8;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic [NP*BW-1:0]  s_paddr = '0;
    logic [NP-1:0]     s_pwrite = '0;
    logic [NP-1:0]     s_psel = '0;
    logic [NP-1:0]     s_penable = '0;
    logic [NP*DW-1:0]  s_pwdata = '0;
    logic [NP*DW-1:0]  s_prdata;
    logic [NP-1:0]     s_pready;
    logic [BW-1:0]     m_paddr;
    logic              m_pwrite;
    logic              m_psel;
    logic              m_penable;
    logic [DW-1:0]     m_pwdata;
    logic [DW-1:0]     m_prdata = '0;
    logic              m_pready;
    logic [NP-1:0]     grant;
    logic              timeout_err;
    logic [1:0]        fsm_state;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic [NP-1:0] rdy_seen = '0;
    int slave_waits = 0;
    logic slave_hang = 1'b0;
    int acc_cnt = 0;
    logic [DW-1:0] exp_q[$];
    logic [NP-1:0] exp_g_q[$];

    typedef struct {
        int            core;
        logic          wr;
        logic [BW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] rdata;
        int            waits;
        logic [NP-1:0] exp_grant;
    } vec_t;
    vec_t vecs[4];

    vmicro16_apb_rr_arbiter #(
        .BUS_WIDTH(BW), .DATA_WIDTH(DW), .MASTER_PORTS(NP), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .reset(reset),
        .S_PADDR(s_paddr), .S_PWRITE(s_pwrite), .S_PSELx(s_psel), .S_PENABLE(s_penable),
        .S_PWDATA(s_pwdata), .S_PRDATA(s_prdata), .S_PREADY(s_pready),
        .M_PADDR(m_paddr), .M_PWRITE(m_pwrite), .M_PSELx(m_psel), .M_PENABLE(m_penable),
        .M_PWDATA(m_pwdata), .M_PRDATA(m_prdata), .M_PREADY(m_pready),
        .grant(grant), .timeout_err(timeout_err), .fsm_state(fsm_state)
    );

    // Clock and slave model: ready after slave_waits ACCESS cycles unless hung.
    always #5 clk = ~clk;

    always @(posedge clk) acc_cnt <= (m_psel && m_penable && !m_pready) ? acc_cnt + 1 : 0;
    assign m_pready = m_psel && m_penable && !slave_hang && (acc_cnt >= slave_waits);

    always @(negedge clk) rdy_seen = s_pready;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Advance one cycle; cores that saw their PREADY drop PSELx.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        s_psel    = s_psel & ~rdy_seen;
        s_penable = s_psel;
    endtask

    task automatic request(input int c, input logic wr, input logic [BW-1:0] addr,
                           input logic [DW-1:0] wdata);
        s_paddr[c*BW +: BW]  = addr;
        s_pwrite[c]          = wr;
        s_pwdata[c*DW +: DW] = wdata;
        s_psel[c]            = 1'b1;
        s_penable[c]         = 1'b1;
    endtask

    task automatic drain(input int limit);
        int last;
        logic [NP-1:0] cur_g;
        logic [DW-1:0] e;
        logic [NP-1:0] g;
        logic fin;
        last  = -1;
        cur_g = '0;
        fin   = 1'b0;
        for (int k = 0; k < limit && !fin; k++) begin
            step();
            @(negedge clk);
            if (m_psel && !m_penable) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL extra_setup: got wdata %h expected no transfer", m_pwdata);
                end else begin
                    e = exp_q.pop_front();
                    g = exp_g_q.pop_front();
                    check("seq_wdata", m_pwdata, e);
                    check("seq_grant", grant, g);
                    if (last >= 0) check("seq_spacing", cyc - last, 3);
                    last  = cyc;
                    cur_g = g;
                end
            end
            if (m_penable && m_pready) check("seq_pready", s_pready, cur_g);
            if (exp_q.size() == 0 && s_psel == '0 && !m_psel) fin = 1'b1;
        end
        if (!fin) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
            exp_q.delete();
            exp_g_q.delete();
        end
    endtask

    task automatic run_single(input vec_t v);
        logic [NP*DW-1:0] e;
        e = '0;
        e[v.core*DW +: DW] = v.rdata;
        step();
        request(v.core, v.wr, v.addr, v.wdata);
        slave_waits = v.waits;
        m_prdata    = v.rdata;
        @(negedge clk);
        check("idle_psel", m_psel, 0);
        step();
        @(negedge clk);
        check("setup_psel", m_psel, 1);
        check("setup_penable", m_penable, 0);
        check("setup_addr", m_paddr, v.addr);
        check("setup_write", m_pwrite, v.wr);
        check("setup_wdata", m_pwdata, v.wdata);
        check("setup_grant", grant, v.exp_grant);
        for (int w = 0; w < v.waits; w++) begin
            step();
            @(negedge clk);
            check("wait_penable", m_penable, 1);
            check("wait_pready", s_pready, 0);
            check("wait_addr", m_paddr, v.addr);
            check("wait_wdata", m_pwdata, v.wdata);
        end
        step();
        @(negedge clk);
        check("done_pready", s_pready, v.exp_grant);
        check("done_prdata", s_prdata, e);
        check("done_timeout_err", timeout_err, 0);
        step();
        @(negedge clk);
        check("after_psel", m_psel, 0);
        check("after_grant", grant, 0);
    endtask

    initial begin
        vecs[0] = '{1, 1'b0, 16'h0040, 16'h0000, 16'h1234, 0, 4'b0010};
        vecs[1] = '{3, 1'b1, 16'h0100, 16'hBEEF, 16'h5A5A, 0, 4'b1000};
        vecs[2] = '{0, 1'b0, 16'h00FE, 16'h0000, 16'hA5A5, 5, 4'b0001};
        vecs[3] = '{2, 1'b1, 16'hFFFF, 16'h0001, 16'h0F0F, 2, 4'b0100};

        // Reset state
        repeat (3) step();
        @(negedge clk);
        check("rst_psel", m_psel, 0);
        check("rst_penable", m_penable, 0);
        check("rst_paddr", m_paddr, 0);
        check("rst_pwdata", m_pwdata, 0);
        check("rst_pwrite", m_pwrite, 0);
        check("rst_grant", grant, 0);
        check("rst_timeout_err", timeout_err, 0);
        check("rst_pready", s_pready, 0);
        check("rst_prdata", s_prdata, 0);
        check("rst_state", fsm_state, 0);

        // All four cores write together straight out of reset
        step();
        reset = 1'b1;
        slave_waits = 0;
        for (int c = 0; c < NP; c++) begin
            request(c, 1'b1, 16'h0100 + 16'(c), 16'h00C0 + 16'(c));
            exp_q.push_back(16'h00C0 + 16'(c));
        end
        exp_g_q.push_back(4'b0001);
        exp_g_q.push_back(4'b0010);
        exp_g_q.push_back(4'b0100);
        exp_g_q.push_back(4'b1000);
        drain(40);

        for (int i = 0; i < 4; i++) run_single(vecs[i]);

        // Fairness: pointer sits at 3 after core 2, so core 0 wins before core 2
        step();
        slave_waits = 0;
        request(0, 1'b1, 16'h0A00, 16'h0A00);
        request(2, 1'b1, 16'h0A02, 16'h0A02);
        exp_q.push_back(16'h0A00);  exp_g_q.push_back(4'b0001);
        exp_q.push_back(16'h0A02);  exp_g_q.push_back(4'b0100);
        drain(30);

        // Watchdog abort on the 8th ACCESS cycle
        step();
        request(1, 1'b0, 16'h0077, 16'h0000);
        slave_hang = 1'b1;
        m_prdata   = 16'hDEAD;
        @(negedge clk);
        step();
        @(negedge clk);
        check("to_grant", grant, 4'b0010);
        for (int a = 1; a < TO; a++) begin
            step();
            @(negedge clk);
            check("to_wait_pready", s_pready, 0);
            check("to_wait_err", timeout_err, 0);
        end
        step();
        @(negedge clk);
        check("to_err", timeout_err, 1);
        check("to_pready", s_pready, 4'b0010);
        check("to_prdata", s_prdata, 0);
        step();
        @(negedge clk);
        check("to_err_clear", timeout_err, 0);
        check("to_psel_idle", m_psel, 0);
        check("to_state_idle", fsm_state, 0);
        slave_hang = 1'b0;

        // Reset during ACCESS abandons the transfer and clears the pointer
        step();
        request(2, 1'b1, 16'h0222, 16'h2222);
        slave_hang = 1'b1;
        @(negedge clk);
        step();
        @(negedge clk);
        step();
        @(negedge clk);
        check("mid_in_access", m_penable, 1);
        reset = 1'b0;
        #1;
        check("mid_no_pready", s_pready, 0);
        step();
        @(negedge clk);
        check("mid_psel", m_psel, 0);
        check("mid_penable", m_penable, 0);
        check("mid_grant", grant, 0);
        check("mid_pready", s_pready, 0);
        check("mid_state", fsm_state, 0);
        step();
        reset      = 1'b1;
        s_psel     = '0;
        s_penable  = '0;
        slave_hang = 1'b0;
        request(0, 1'b1, 16'h0D00, 16'h0D00);
        request(3, 1'b1, 16'h0D03, 16'h0D03);
        exp_q.push_back(16'h0D00);  exp_g_q.push_back(4'b0001);
        exp_q.push_back(16'h0D03);  exp_g_q.push_back(4'b1000);
        drain(30);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
